// File: rtl/rv64_pkg.sv
// Shared RV64 integer-pipeline types: register index / data widths and the
// write-back entry carried from execute/memory to the register-file port.
package rv64_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      value;
    } wb_entry_t;

    // x0 is hard-wired to zero, so a result aimed at it carries no information.
    function automatic logic is_writable(input logic vld, input logic [REG_IDX_W-1:0] rd);
        return vld && (rd != '0);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Dual-enqueue, single-dequeue circular buffer of write-back entries. Storage,
// count and pointers are exported so the owner can search pending entries.
module wb_fifo
    import rv64_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [1:0]            enq_cnt_i,
    input  wb_entry_t             enq0_i,
    input  wb_entry_t             enq1_i,
    input  logic                  deq_i,
    output wb_entry_t             head_o,
    output logic [CNT_W-1:0]      count_o,
    output logic [PTR_W-1:0]      rd_ptr_o,
    output logic [PTR_W-1:0]      wr_ptr_o,
    output wb_entry_t [DEPTH-1:0] entries_o
);

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    // The owner never asks for more slots than are free after the dequeue.
    always_comb begin
        mem_d = mem_q;
        if (enq_cnt_i != 2'd0) begin
            mem_d[wr_ptr_q] = enq0_i;
        end
        if (enq_cnt_i == 2'd2) begin
            mem_d[wr_ptr_q + PTR_W'(1)] = enq1_i;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(enq_cnt_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(deq_i);
        count_d  = count_q + CNT_W'(enq_cnt_i) - CNT_W'(deq_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign rd_ptr_o  = rd_ptr_q;
    assign wr_ptr_o  = wr_ptr_q;
    assign entries_o = mem_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and LSU results onto the single register-file write port, in order.
// Define WB_ARB_FWD_EN to build the pending-entry forward search for decode.
module regfile_wb_arbiter
    import rv64_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_value,
    input  logic                 lsu_valid,
    input  logic [REG_IDX_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]      lsu_value,
    input  logic [REG_IDX_W-1:0] fwd_rs,
    output logic                 fwd_hit,
    output logic [XLEN-1:0]      fwd_value,
    output logic                 wb_en,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_value,
    output logic                 stall_req,
    output logic                 err_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t             lsu_req, alu_req;
    logic                  lsu_vld, alu_vld;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [CNT_W-1:0]      count;
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic                  fifo_empty, fifo_full;

    logic [1:0]            enq_cnt;
    wb_entry_t             enq0, enq1;
    logic                  deq;
    logic                  drop;

    logic                  wb_en_q, wb_en_d;
    logic [REG_IDX_W-1:0]  wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]       wb_value_q, wb_value_d;
    logic                  err_q, err_d;

    assign lsu_req.rd    = lsu_rd;
    assign lsu_req.value = lsu_value;
    assign alu_req.rd    = alu_rd;
    assign alu_req.value = alu_value;
    assign lsu_vld       = is_writable(lsu_valid, lsu_rd);
    assign alu_vld       = is_writable(alu_valid, alu_rd);

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(DEPTH));

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_i     (reset),
        .enq_cnt_i (enq_cnt),
        .enq0_i    (enq0),
        .enq1_i    (enq1),
        .deq_i     (deq),
        .head_o    (head),
        .count_o   (count),
        .rd_ptr_o  (rd_ptr),
        .wr_ptr_o  (wr_ptr),
        .entries_o (entries)
    );

    // The oldest of {queued entries, LSU, ALU} always takes the write port;
    // with an empty queue this is the bypass path.
    always_comb begin
        enq_cnt    = 2'd0;
        enq0       = lsu_req;
        enq1       = alu_req;
        deq        = 1'b0;
        drop       = 1'b0;
        wb_en_d    = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_value_d = wb_value_q;
        if (fifo_empty) begin
            if (lsu_vld) begin
                wb_en_d    = 1'b1;
                wb_rd_d    = lsu_req.rd;
                wb_value_d = lsu_req.value;
                if (alu_vld) begin
                    enq0    = alu_req;
                    enq_cnt = 2'd1;
                end
            end else if (alu_vld) begin
                wb_en_d    = 1'b1;
                wb_rd_d    = alu_req.rd;
                wb_value_d = alu_req.value;
            end
        end else begin
            deq        = 1'b1;
            wb_en_d    = 1'b1;
            wb_rd_d    = head.rd;
            wb_value_d = head.value;
            if (lsu_vld && alu_vld) begin
                // A full queue frees only the dequeued slot; the ALU result is the youngest.
                enq_cnt = fifo_full ? 2'd1 : 2'd2;
                drop    = fifo_full;
            end else if (lsu_vld) begin
                enq_cnt = 2'd1;
            end else if (alu_vld) begin
                enq0    = alu_req;
                enq_cnt = 2'd1;
            end
        end
        err_d = err_q | drop;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wb_en_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_value_q <= '0;
            err_q      <= 1'b0;
        end else begin
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_value_q <= wb_value_d;
            err_q      <= err_d;
        end
    end

    assign wb_en        = wb_en_q;
    assign wb_rd        = wb_rd_q;
    assign wb_value     = wb_value_q;
    assign err_overflow = err_q;
    assign stall_req    = (CNT_W'(DEPTH) - count) < CNT_W'(2);

    logic unused_wr_ptr;
    assign unused_wr_ptr = ^wr_ptr;

`ifdef WB_ARB_FWD_EN
    logic            fwd_hit_c;
    logic [XLEN-1:0] fwd_value_c;

    // Walk oldest to youngest so the last match seen is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = rd_ptr;
        fwd_hit_c   = 1'b0;
        fwd_value_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if ((CNT_W'(i) < count) && (fwd_rs != '0) && (entries[idx].rd == fwd_rs)) begin
                fwd_hit_c   = 1'b1;
                fwd_value_c = entries[idx].value;
            end
        end
    end

    assign fwd_hit   = fwd_hit_c;
    assign fwd_value = fwd_value_c;
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_rs, rd_ptr, entries};
    assign fwd_hit    = 1'b0;
    assign fwd_value  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a queue-based reference model checked
// every cycle, plus hand-computed literal expectations along the stimulus.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_rd = '0;
    logic [63:0] alu_value = '0;
    logic        lsu_valid = 1'b0;
    logic [4:0]  lsu_rd = '0;
    logic [63:0] lsu_value = '0;
    logic [4:0]  fwd_rs = '0;
    logic        fwd_hit;
    logic [63:0] fwd_value;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [63:0] wb_value;
    logic        stall_req;
    logic        err_overflow;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_value    (alu_value),
        .lsu_valid    (lsu_valid),
        .lsu_rd       (lsu_rd),
        .lsu_value    (lsu_value),
        .fwd_rs       (fwd_rs),
        .fwd_hit      (fwd_hit),
        .fwd_value    (fwd_value),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_value     (wb_value),
        .stall_req    (stall_req),
        .err_overflow (err_overflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending results as a plain ordered list.
    typedef struct {
        logic [4:0]  rd;
        logic [63:0] v;
    } ent_t;

    ent_t        q[$];
    logic        m_en  = 1'b0;
    logic [4:0]  m_rd  = '0;
    logic [63:0] m_val = '0;
    logic        m_err = 1'b0;

    // Inputs are held from negedge+1 to the next negedge, so at a negedge they
    // are exactly what the preceding rising edge sampled.
    always @(negedge CLK) begin
        ent_t t[$];
        ent_t e;
        logic        e_hit;
        logic [63:0] e_fval;
        if (reset) begin
            q.delete();
            m_en  = 1'b0;
            m_rd  = '0;
            m_val = '0;
            m_err = 1'b0;
        end else begin
            t = q;
            if (lsu_valid && lsu_rd != 5'd0) begin
                e.rd = lsu_rd; e.v = lsu_value; t.push_back(e);
            end
            if (alu_valid && alu_rd != 5'd0) begin
                e.rd = alu_rd; e.v = alu_value; t.push_back(e);
            end
            if (t.size() > 0) begin
                e = t.pop_front();
                m_en = 1'b1; m_rd = e.rd; m_val = e.v;
            end else begin
                m_en = 1'b0;
            end
            if (t.size() > DEPTH) begin
                void'(t.pop_back());
                m_err = 1'b1;
            end
            q = t;
        end
        e_hit  = 1'b0;
        e_fval = '0;
`ifdef WB_ARB_FWD_EN
        if (fwd_rs != 5'd0) begin
            foreach (q[i]) begin
                if (q[i].rd == fwd_rs) begin
                    e_hit = 1'b1; e_fval = q[i].v;
                end
            end
        end
`endif
        chk("m_wb_en", wb_en, m_en);
        if (m_en) begin
            chk("m_wb_rd", wb_rd, m_rd);
            chk("m_wb_value", wb_value, m_val);
        end
        chk("m_stall", stall_req, (DEPTH - int'(q.size())) < 2);
        chk("m_err", err_overflow, m_err);
        chk("m_fwd_hit", fwd_hit, e_hit);
        if (e_hit) chk("m_fwd_value", fwd_value, e_fval);
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic req(input logic lv, input logic [4:0] lrd, input logic [63:0] lval,
                       input logic av, input logic [4:0] ard, input logic [63:0] aval);
        lsu_valid = lv; lsu_rd = lrd; lsu_value = lval;
        alu_valid = av; alu_rd = ard; alu_value = aval;
    endtask

    task automatic idle();
        req(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    task automatic dual(input logic [4:0] lrd, input logic [4:0] ard);
        req(1'b1, lrd, 64'h1000 + 64'(lrd), 1'b1, ard, 64'h1000 + 64'(ard));
    endtask

    task automatic chk_wb(input string nm, input logic [4:0] rd, input logic [63:0] v);
        chk({nm, "_en"}, wb_en, 1'b1);
        chk({nm, "_rd"}, wb_rd, rd);
        chk({nm, "_value"}, wb_value, v);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_wb_en", wb_en, 1'b0);
        chk("rst_wb_rd", wb_rd, 5'd0);
        chk("rst_wb_value", wb_value, 64'd0);
        chk("rst_stall", stall_req, 1'b0);
        chk("rst_err", err_overflow, 1'b0);
        chk("rst_fwd_hit", fwd_hit, 1'b0);
        chk("rst_fwd_value", fwd_value, 64'd0);
        reset = 1'b0;
        tick();

        // Single ALU result: one-cycle latency, one-cycle strobe.
        req(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'h11);
        tick();
        chk_wb("alu1", 5'd5, 64'h11);
        idle();
        tick();
        chk("alu1_done", wb_en, 1'b0);

        // Collision into empty queue: LSU first, ALU next.
        req(1'b1, 5'd3, 64'hAA, 1'b1, 5'd4, 64'hBB);
        fwd_rs = 5'd4;
        tick();
        chk_wb("col_lsu", 5'd3, 64'hAA);
`ifdef WB_ARB_FWD_EN
        chk("col_fwd_hit", fwd_hit, 1'b1);
        chk("col_fwd_value", fwd_value, 64'hBB);
`endif
        idle();
        tick();
        chk_wb("col_alu", 5'd4, 64'hBB);
        chk("col_fwd_gone", fwd_hit, 1'b0);
        tick();
        chk("col_done", wb_en, 1'b0);

        // x0 writes vanish.
        fwd_rs = 5'd0;
        req(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFF);
        tick();
        chk("x0_wb_en", wb_en, 1'b0);
        chk("x0_stall", stall_req, 1'b0);
        idle();
        tick();
        chk("x0_wb_en2", wb_en, 1'b0);

        // Three dual cycles: stall rises at count 3, no overflow.
        dual(5'd1, 5'd2);
        tick();
        chk_wb("d1", 5'd1, 64'h1001);
        dual(5'd6, 5'd8);
        tick();
        chk_wb("d2", 5'd2, 64'h1002);
        chk("d2_stall", stall_req, 1'b0);
        dual(5'd9, 5'd10);
        tick();
        chk_wb("d3", 5'd6, 64'h1006);
        chk("d3_stall", stall_req, 1'b1);
        chk("d3_err", err_overflow, 1'b0);
        idle();
        tick();
        chk_wb("dr1", 5'd8, 64'h1008);
        chk("dr1_stall", stall_req, 1'b0);
        tick();
        chk_wb("dr2", 5'd9, 64'h1009);
        tick();
        chk_wb("dr3", 5'd10, 64'h100A);
        tick();
        chk("dr_done", wb_en, 1'b0);

        // Ignore stall: rd 20 from the fifth dual is dropped.
        dual(5'd11, 5'd12); tick(); chk_wb("o0", 5'd11, 64'h100B);
        dual(5'd13, 5'd14); tick(); chk_wb("o1", 5'd12, 64'h100C);
        dual(5'd15, 5'd16); tick(); chk_wb("o2", 5'd13, 64'h100D);
        dual(5'd17, 5'd18); tick(); chk_wb("o3", 5'd14, 64'h100E);
        chk("o3_err", err_overflow, 1'b0);
        dual(5'd19, 5'd20); tick(); chk_wb("o4", 5'd15, 64'h100F);
        chk("o4_err", err_overflow, 1'b1);
        chk("o4_stall", stall_req, 1'b1);
        idle();
        tick(); chk_wb("od0", 5'd16, 64'h1010);
        tick(); chk_wb("od1", 5'd17, 64'h1011);
        tick(); chk_wb("od2", 5'd18, 64'h1012);
        tick(); chk_wb("od3", 5'd19, 64'h1013);
        tick();
        chk("od_done", wb_en, 1'b0);
        chk("od_err_sticky", err_overflow, 1'b1);

        // Two pending writes to x7: youngest wins; then reset mid-drain.
        dual(5'd20, 5'd21); tick();
        dual(5'd22, 5'd23); tick();
        req(1'b1, 5'd7, 64'h1, 1'b1, 5'd7, 64'h2);
        fwd_rs = 5'd7;
        tick();
        chk_wb("f2", 5'd22, 64'h1016);
`ifdef WB_ARB_FWD_EN
        chk("f2_fwd_hit", fwd_hit, 1'b1);
        chk("f2_fwd_value", fwd_value, 64'h2);
`endif
        idle();
        tick();
        chk_wb("f3", 5'd23, 64'h1017);
        reset = 1'b1;
        #1;
        chk("mid_rst_wb_en", wb_en, 1'b0);
        chk("mid_rst_wb_rd", wb_rd, 5'd0);
        chk("mid_rst_wb_value", wb_value, 64'd0);
        chk("mid_rst_err", err_overflow, 1'b0);
        chk("mid_rst_stall", stall_req, 1'b0);
        chk("mid_rst_fwd_hit", fwd_hit, 1'b0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_en0", wb_en, 1'b0);
        tick();
        chk("post_rst_en1", wb_en, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
